// File: rtl/bram_if_pkg.sv
// Shared defaults and helpers for the block-RAM port initiator slice.
// Holds word geometry, the two supported read latencies and the credit-width rule.
package bram_if_pkg;

    localparam int NB_COL_DEF    = 4;
    localparam int COL_WIDTH_DEF = 8;
    localparam int W_DEF         = NB_COL_DEF * COL_WIDTH_DEF;
    localparam int ADDR_W_DEF    = 11;
    localparam int RSP_DEPTH_DEF = 4;

    localparam int LAT_LOW  = 1;
    localparam int LAT_HIGH = 2;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_port_initiator_if.sv
// CPU-side request/response channels of the block-RAM port initiator.
// The master modport is the requester; the slave modport is the initiator itself.
interface bram_port_initiator_if
    import bram_if_pkg::*;
#(
    parameter int NB_COL    = NB_COL_DEF,
    parameter int COL_WIDTH = COL_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) ();

    localparam int W = NB_COL * COL_WIDTH;

    logic              req_valid;
    logic              req_ready;
    logic [NB_COL-1:0] req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [W-1:0]      req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/bram_rsp_fifo.sv
// Synchronous response FIFO with registered storage and an occupancy count.
// A pop on an empty FIFO is ignored; push and pop together keep the count steady.
module bram_rsp_fifo
    import bram_if_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEF,
    parameter int WIDTH = W_DEF
) (
    input  logic                       clka,
    input  logic                       rstb,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNW'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clka) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            count <= count + CNW'(do_push) - CNW'(do_pop);
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/bram_port_initiator.sv
// Requester-side front end for one byte-write block-RAM port: issues requests,
// follows the fixed read latency and returns read data under credit flow control.
module bram_port_initiator
    import bram_if_pkg::*;
#(
    parameter int NB_COL       = NB_COL_DEF,
    parameter int COL_WIDTH    = COL_WIDTH_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int READ_LATENCY = LAT_LOW,
    parameter int RSP_DEPTH    = RSP_DEPTH_DEF
) (
    input  logic                          clka,
    input  logic                          rstb,
    bram_port_initiator_if.slave          cpu,
    output logic                          mem_en,
    output logic [NB_COL-1:0]             mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [NB_COL*COL_WIDTH-1:0]   mem_din,
    output logic                          mem_regce,
    output logic                          mem_rst,
    input  logic [NB_COL*COL_WIDTH-1:0]   mem_dout,
    output logic                          busy
);

    localparam int W   = NB_COL * COL_WIDTH;
    localparam int CW  = credit_width(RSP_DEPTH);
    localparam int FCW = $clog2(RSP_DEPTH + 1);

    generate
        if (READ_LATENCY != LAT_LOW && READ_LATENCY != LAT_HIGH) begin : g_bad_latency
            $error("bram_port_initiator: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [CW-1:0]           credits;
    logic [READ_LATENCY-1:0] pipe;
    logic [FCW-1:0]          fifo_count;
    logic                    is_read;
    logic                    accept;
    logic                    read_accept;
    logic                    pop;
    logic                    push;
    int                      in_flight;

    // Writes bypass the credit check because they never produce a response.
    assign is_read       = (cpu.req_we == '0);
    assign cpu.req_ready = !rstb && ((credits != '0) || !is_read);
    assign accept        = cpu.req_valid && cpu.req_ready;
    assign read_accept   = accept && is_read;
    assign pop           = cpu.rsp_valid && cpu.rsp_ready;
    assign push          = pipe[READ_LATENCY-1];

    assign mem_en    = accept;
    assign mem_we    = accept ? cpu.req_we : '0;
    assign mem_addr  = cpu.req_addr;
    assign mem_din   = cpu.req_wdata;
    assign mem_regce = !rstb;
    assign mem_rst   = rstb;

    assign busy = (pipe != '0) || (fifo_count != '0);

    always_comb begin
        in_flight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (pipe[i]) in_flight++;
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            pipe <= '0;
        end else begin
            pipe[0] <= read_accept;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Every credit is either free, riding the read pipe, or parked in the FIFO.
    always_ff @(posedge clka) begin
        if (rstb) begin
            credits <= CW'(RSP_DEPTH);
        end else begin
            credits <= credits - CW'(read_accept) + CW'(pop);
            assert (int'(credits) + in_flight + int'(fifo_count) == RSP_DEPTH);
        end
    end

    bram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (W)
    ) u_rsp_fifo (
        .clka  (clka),
        .rstb  (rstb),
        .push  (push),
        .din   (mem_dout),
        .pop   (pop),
        .dout  (cpu.rsp_rdata),
        .valid (cpu.rsp_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator: one instance at each read latency,
// each backed by a behavioural read-first byte-write RAM.
module tb_bram_port_initiator;

    logic clka = 1'b0;
    logic rstb;
    int   total = 0;
    int   bad = 0;

    always #5 clka = ~clka;

    bram_port_initiator_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(11)) if1 ();
    bram_port_initiator_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(11)) if2 ();

    logic        m1_en, m1_regce, m1_rst, m1_busy;
    logic [3:0]  m1_we;
    logic [10:0] m1_addr;
    logic [31:0] m1_din, m1_dout;
    logic        m2_en, m2_regce, m2_rst, m2_busy;
    logic [3:0]  m2_we;
    logic [10:0] m2_addr;
    logic [31:0] m2_din, m2_dout, m2_stage;
    logic [31:0] ram1 [2048];
    logic [31:0] ram2 [2048];

    bram_port_initiator #(.READ_LATENCY(1), .RSP_DEPTH(4)) dut1 (
        .clka(clka), .rstb(rstb), .cpu(if1),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_din(m1_din),
        .mem_regce(m1_regce), .mem_rst(m1_rst), .mem_dout(m1_dout), .busy(m1_busy)
    );

    bram_port_initiator #(.READ_LATENCY(2), .RSP_DEPTH(4)) dut2 (
        .clka(clka), .rstb(rstb), .cpu(if2),
        .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr), .mem_din(m2_din),
        .mem_regce(m2_regce), .mem_rst(m2_rst), .mem_dout(m2_dout), .busy(m2_busy)
    );

    // Low-latency RAM: read-first, output valid one cycle after en.
    always @(posedge clka) begin
        if (m1_rst) m1_dout <= '0;
        else if (m1_en) m1_dout <= ram1[m1_addr];
        if (m1_en)
            for (int b = 0; b < 4; b++)
                if (m1_we[b]) ram1[m1_addr][8*b +: 8] <= m1_din[8*b +: 8];
    end

    // High-performance RAM: extra output register gated by regce.
    always @(posedge clka) begin
        if (m2_rst) m2_stage <= '0;
        else if (m2_en) m2_stage <= ram2[m2_addr];
        if (m2_rst) m2_dout <= '0;
        else if (m2_regce) m2_dout <= m2_stage;
        if (m2_en)
            for (int b = 0; b < 4; b++)
                if (m2_we[b]) ram2[m2_addr][8*b +: 8] <= m2_din[8*b +: 8];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic req1(input logic v, input logic [3:0] we, input logic [10:0] a,
                        input logic [31:0] d, input logic rdy);
        @(negedge clka);
        if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = d;
        if1.rsp_ready = rdy;
        #1;
    endtask

    task automatic req2(input logic v, input logic [3:0] we, input logic [10:0] a,
                        input logic [31:0] d, input logic rdy);
        @(negedge clka);
        if2.req_valid = v; if2.req_we = we; if2.req_addr = a; if2.req_wdata = d;
        if2.rsp_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        req1(1'b1, 4'hF, 11'd5, 32'h1, 1'b1);
        total++; if (if1.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_ready got=%0b exp=0", if1.req_ready); end
        total++; if (m1_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_en got=%0b exp=0", m1_en); end
        total++; if (m1_we !== 4'h0) begin bad++; $display("[TB] FAIL rst_mem_we got=%0h exp=0", m1_we); end
        total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid got=%0b exp=0", if1.rsp_valid); end
        total++; if (m1_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0b exp=0", m1_busy); end
        total++; if (m1_rst !== 1'b1) begin bad++; $display("[TB] FAIL rst_mem_rst got=%0b exp=1", m1_rst); end
        total++; if (m1_regce !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_regce got=%0b exp=0", m1_regce); end
        total++; if (if2.req_ready !== 1'b0 || if2.rsp_valid !== 1'b0 || m2_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_dut2 got=%0b%0b%0b exp=000", if2.req_ready, if2.rsp_valid, m2_busy); end
        @(negedge clka);
        rstb = 1'b0;
        if1.req_valid = 1'b0; if1.req_we = 4'h0;
        #1;
        total++; if (if1.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_req_ready got=%0b exp=1", if1.req_ready); end
        total++; if (m1_regce !== 1'b1 || m1_rst !== 1'b0) begin bad++; $display("[TB] FAIL rel_regce_rst got=%0b%0b exp=10", m1_regce, m1_rst); end
    endtask

    task automatic preload1();
        for (int i = 0; i < 5; i++) req1(1'b1, 4'hF, 11'(i), 32'h1000_0000 + i, 1'b0);
        req1(1'b1, 4'hF, 11'd5, 32'hDEAD_BEEF, 1'b0);
        req1(1'b1, 4'hF, 11'd7, 32'hAABB_CCDD, 1'b0);
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b0);
    endtask

    task automatic test_single_read();
        req1(1'b1, 4'h0, 11'd5, 32'h0, 1'b1);
        total++; if (m1_en !== 1'b1 || m1_addr !== 11'd5 || m1_we !== 4'h0) begin bad++; $display("[TB] FAIL t1_issue got=en%0b addr%0d we%0h exp=en1 addr5 we0", m1_en, m1_addr, m1_we); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0 || m1_busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_n1 got=valid%0b busy%0b exp=valid0 busy1", if1.rsp_valid, m1_busy); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL t1_rsp got=valid%0b %h exp=valid1 deadbeef", if1.rsp_valid, if1.rsp_rdata); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0 || m1_busy !== 1'b0) begin bad++; $display("[TB] FAIL t1_n3 got=valid%0b busy%0b exp=valid0 busy0", if1.rsp_valid, m1_busy); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            req1(1'b1, 4'h0, 11'(i), 32'h0, 1'b0);
            total++; if (if1.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t2_accept%0d got=%0b exp=1", i, if1.req_ready); end
        end
        for (int i = 0; i < 2; i++) begin
            req1(1'b1, 4'h0, 11'd4, 32'h0, 1'b0);
            total++; if (if1.req_ready !== 1'b0 || m1_en !== 1'b0) begin bad++; $display("[TB] FAIL t2_stall%0d got=ready%0b en%0b exp=ready0 en0", i, if1.req_ready, m1_en); end
        end
        req1(1'b1, 4'hF, 11'd8, 32'h0000_0055, 1'b0);
        total++; if (if1.req_ready !== 1'b1 || m1_en !== 1'b1 || m1_we !== 4'hF) begin bad++; $display("[TB] FAIL t2_write got=ready%0b en%0b we%0h exp=ready1 en1 weF", if1.req_ready, m1_en, m1_we); end
        total++; if (if1.rsp_valid !== 1'b1 || m1_busy !== 1'b1) begin bad++; $display("[TB] FAIL t2_held got=valid%0b busy%0b exp=valid1 busy1", if1.rsp_valid, m1_busy); end
        for (int k = 0; k < 4; k++) begin
            req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
            total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== 32'h1000_0000 + k) begin bad++; $display("[TB] FAIL t2_drain%0d got=valid%0b %h exp=valid1 %h", k, if1.rsp_valid, if1.rsp_rdata, 32'h1000_0000 + k); end
        end
        req1(1'b1, 4'h0, 11'd4, 32'h0, 1'b1);
        total++; if (if1.req_ready !== 1'b1 || if1.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t2_rd4 got=ready%0b valid%0b exp=ready1 valid0", if1.req_ready, if1.rsp_valid); end
        req1(1'b1, 4'h0, 11'd5, 32'h0, 1'b1);
        total++; if (if1.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t2_rd5 got=%0b exp=1", if1.req_ready); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== 32'h1000_0004) begin bad++; $display("[TB] FAIL t2_rsp4 got=valid%0b %h exp=valid1 10000004", if1.rsp_valid, if1.rsp_rdata); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL t2_rsp5 got=valid%0b %h exp=valid1 deadbeef", if1.rsp_valid, if1.rsp_rdata); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0 || m1_busy !== 1'b0) begin bad++; $display("[TB] FAIL t2_idle got=valid%0b busy%0b exp=valid0 busy0", if1.rsp_valid, m1_busy); end
    endtask

    task automatic test_write_merge();
        req1(1'b1, 4'b0101, 11'd7, 32'h1122_3344, 1'b1);
        total++; if (m1_we !== 4'b0101 || m1_din !== 32'h1122_3344 || m1_addr !== 11'd7) begin bad++; $display("[TB] FAIL t3_write got=we%0h din%h addr%0d exp=we5 din11223344 addr7", m1_we, m1_din, m1_addr); end
        req1(1'b1, 4'h0, 11'd7, 32'h0, 1'b1);
        total++; if (m1_en !== 1'b1 || if1.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t3_read got=en%0b valid%0b exp=en1 valid0", m1_en, if1.rsp_valid); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t3_no_write_rsp got=%0b exp=0", if1.rsp_valid); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== 32'hAA22_CC44) begin bad++; $display("[TB] FAIL t3_merge got=valid%0b %h exp=valid1 aa22cc44", if1.rsp_valid, if1.rsp_rdata); end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t3_after got=%0b exp=0", if1.rsp_valid); end
    endtask

    task automatic test_full_pop_accept();
        logic [31:0] exp_data [6];
        for (int i = 0; i < 5; i++) exp_data[i] = 32'h1000_0000 + i;
        exp_data[5] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) req1(1'b1, 4'h0, 11'(i), 32'h0, 1'b0);
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b0);
        total++; if (if1.req_ready !== 1'b0 || m1_busy !== 1'b1) begin bad++; $display("[TB] FAIL t6_nocredit got=ready%0b busy%0b exp=ready0 busy1", if1.req_ready, m1_busy); end
        req1(1'b1, 4'h0, 11'd4, 32'h0, 1'b1);
        total++; if (if1.req_ready !== 1'b0 || if1.rsp_rdata !== exp_data[0]) begin bad++; $display("[TB] FAIL t6_full_pop got=ready%0b %h exp=ready0 %h", if1.req_ready, if1.rsp_rdata, exp_data[0]); end
        req1(1'b1, 4'h0, 11'd4, 32'h0, 1'b1);
        total++; if (if1.req_ready !== 1'b1 || if1.rsp_rdata !== exp_data[1]) begin bad++; $display("[TB] FAIL t6_pop_acc1 got=ready%0b %h exp=ready1 %h", if1.req_ready, if1.rsp_rdata, exp_data[1]); end
        req1(1'b1, 4'h0, 11'd5, 32'h0, 1'b1);
        total++; if (if1.req_ready !== 1'b1 || if1.rsp_rdata !== exp_data[2]) begin bad++; $display("[TB] FAIL t6_pop_acc2 got=ready%0b %h exp=ready1 %h", if1.req_ready, if1.rsp_rdata, exp_data[2]); end
        for (int k = 3; k < 6; k++) begin
            req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
            total++; if (if1.rsp_valid !== 1'b1 || if1.rsp_rdata !== exp_data[k]) begin bad++; $display("[TB] FAIL t6_order%0d got=valid%0b %h exp=valid1 %h", k, if1.rsp_valid, if1.rsp_rdata, exp_data[k]); end
        end
        req1(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if1.rsp_valid !== 1'b0 || m1_busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_empty got=valid%0b busy%0b exp=valid0 busy0", if1.rsp_valid, m1_busy); end
    endtask

    task automatic preload2();
        for (int i = 0; i < 16; i++) req2(1'b1, 4'hF, 11'(i), 32'hC0DE_0000 + i, 1'b0);
        req2(1'b0, 4'h0, 11'd0, 32'h0, 1'b0);
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 20; c++) begin
            if (c < 16) req2(1'b1, 4'h0, 11'(c), 32'h0, 1'b1);
            else        req2(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
            if (c < 16) begin
                total++; if (if2.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t4_ready%0d got=%0b exp=1", c, if2.req_ready); end
            end
            if (c >= 3 && c < 19) begin
                total++; if (if2.rsp_valid !== 1'b1 || if2.rsp_rdata !== 32'hC0DE_0000 + (c - 3)) begin bad++; $display("[TB] FAIL t4_rsp%0d got=valid%0b %h exp=valid1 %h", c, if2.rsp_valid, if2.rsp_rdata, 32'hC0DE_0000 + (c - 3)); end
            end else begin
                total++; if (if2.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t4_quiet%0d got=%0b exp=0", c, if2.rsp_valid); end
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 4; i++) begin
            req2(1'b1, 4'h0, 11'(i), 32'h0, 1'b0);
            total++; if (if2.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t5_pre%0d got=%0b exp=1", i, if2.req_ready); end
        end
        @(negedge clka);
        rstb = 1'b1;
        if2.req_valid = 1'b0;
        #1;
        total++; if (if2.req_ready !== 1'b0 || m2_busy !== 1'b1 || if2.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL t5_inrst got=ready%0b busy%0b valid%0b exp=ready0 busy1 valid1", if2.req_ready, m2_busy, if2.rsp_valid); end
        @(negedge clka);
        rstb = 1'b0;
        #1;
        total++; if (if2.rsp_valid !== 1'b0 || m2_busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_cleared got=valid%0b busy%0b exp=valid0 busy0", if2.rsp_valid, m2_busy); end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                if2.req_valid = 1'b1; if2.req_we = 4'h0; if2.req_addr = 11'd0;
                #1;
            end else begin
                req2(1'b1, 4'h0, 11'(i), 32'h0, 1'b0);
            end
            total++; if (if2.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t5_post%0d got=%0b exp=1", i, if2.req_ready); end
        end
        req2(1'b1, 4'h0, 11'd4, 32'h0, 1'b0);
        total++; if (if2.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL t5_fifth got=%0b exp=0", if2.req_ready); end
        req2(1'b0, 4'h0, 11'd0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            req2(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
            total++; if (if2.rsp_valid !== 1'b1 || if2.rsp_rdata !== 32'hC0DE_0000 + k) begin bad++; $display("[TB] FAIL t5_drain%0d got=valid%0b %h exp=valid1 %h", k, if2.rsp_valid, if2.rsp_rdata, 32'hC0DE_0000 + k); end
        end
        req2(1'b0, 4'h0, 11'd0, 32'h0, 1'b1);
        total++; if (if2.rsp_valid !== 1'b0 || m2_busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_end got=valid%0b busy%0b exp=valid0 busy0", if2.rsp_valid, m2_busy); end
    endtask

    initial begin
        rstb = 1'b1;
        if1.req_valid = 1'b0; if1.req_we = 4'h0; if1.req_addr = '0; if1.req_wdata = '0; if1.rsp_ready = 1'b0;
        if2.req_valid = 1'b0; if2.req_we = 4'h0; if2.req_addr = '0; if2.req_wdata = '0; if2.rsp_ready = 1'b0;
        test_reset();
        preload1();
        test_single_read();
        test_backpressure();
        test_write_merge();
        test_full_pop_accept();
        preload2();
        test_streaming();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
